// File: rtl/pcie_tlp_tx_mux_if.sv
// Bundle of FIFO-side and link-side signals for the TLP transmit assembler.
// Signal names are written from the assembler's point of view (_i into it, _o out of it).
interface pcie_tlp_tx_mux_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128
);
    logic [NUM_CH-1:0]           hdr_empty_i;
    logic [NUM_CH*HDR_WIDTH-1:0] hdr_rdata_i;
    logic [NUM_CH-1:0]           hdr_rden_o;
    logic                        pld_empty_i;
    logic [DATA_WIDTH-1:0]       pld_rdata_i;
    logic                        pld_rden_o;
    logic                        tlp_valid_o;
    logic [DATA_WIDTH-1:0]       tlp_data_o;
    logic [DATA_WIDTH/32-1:0]    tlp_keep_o;
    logic                        tlp_sop_o;
    logic                        tlp_eop_o;
    logic                        tlp_ready_i;

    // The assembler itself.
    modport master (
        input  hdr_empty_i, hdr_rdata_i, pld_empty_i, pld_rdata_i, tlp_ready_i,
        output hdr_rden_o, pld_rden_o, tlp_valid_o, tlp_data_o, tlp_keep_o,
        tlp_sop_o, tlp_eop_o
    );

    // FIFOs plus link layer surrounding the assembler.
    modport slave (
        output hdr_empty_i, hdr_rdata_i, pld_empty_i, pld_rdata_i, tlp_ready_i,
        input  hdr_rden_o, pld_rden_o, tlp_valid_o, tlp_data_o, tlp_keep_o,
        tlp_sop_o, tlp_eop_o
    );
endinterface

// File: rtl/pcie_tlp_tx_mux.sv
// Multi-channel TLP transmit assembler: round-robin over header FIFOs, packs
// payload DWs contiguously behind the 4DW header and emits sop/eop/keep beats.
//
//   state  | meaning
//   -------+------------------------------------------------------------------
//   IDLE   | between TLPs; grants a channel and emits header + first payload
//   DATA   | emitting the rest of the payload, carrying the upper 4 DWs over
module pcie_tlp_tx_mux #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 256,
    parameter int HDR_WIDTH  = 128,
    localparam int DWS       = DATA_WIDTH / 32,
    localparam int GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pcie_tlp_tx_mux_if.master      tx,
    output logic [GW-1:0]          grant_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    // DWs of payload that fit in the first beat beside the header.
    localparam logic [10:0] HDR_ROOM = 11'(DWS - 4);
    localparam logic [10:0] DWS_L    = 11'(DWS);

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DWS-1:0]          keep_q, keep_d;
    logic                    sop_q, sop_d;
    logic                    eop_q, eop_d;
    logic [HDR_WIDTH-1:0]    carry_q, carry_d;
    logic [10:0]             rem_q, rem_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]           grant_q, grant_d;

    logic [NUM_CH-1:0]       elig;
    logic                    found;
    logic [GW-1:0]           pick;
    logic [GW:0]             cand;
    logic [HDR_WIDTH-1:0]    hdr_sel;
    logic                    sel_has_data;
    logic [10:0]             sel_len;
    logic [10:0]             take;
    logic                    slot_free;
    logic [NUM_CH-1:0]       hdr_rden;
    logic                    pld_rden;

    function automatic logic [DWS-1:0] dw_mask(input logic [10:0] n);
        logic [DWS-1:0] m;
        m = '0;
        for (int j = 0; j < DWS; j++) begin
            m[j] = (j < int'(n));
        end
        return m;
    endfunction

    assign slot_free = !valid_q || tx.tlp_ready_i;

    // Per-channel eligibility: a read header never waits on payload.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = !tx.hdr_empty_i[c] &&
                      (!tx.hdr_rdata_i[c*HDR_WIDTH + 30] || !tx.pld_empty_i);
        end
    end

    // Round-robin search starting at the pointer; first eligible channel wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(NUM_CH)) begin
                cand = cand - (GW+1)'(NUM_CH);
            end
            if (!found && elig[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    // Header of the winning channel and its decoded fields.
    always_comb begin
        hdr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pick == GW'(c)) begin
                hdr_sel = tx.hdr_rdata_i[c*HDR_WIDTH +: HDR_WIDTH];
            end
        end
        sel_has_data = hdr_sel[30];
        sel_len      = (hdr_sel[9:0] == 10'd0) ? 11'd1024 : {1'b0, hdr_sel[9:0]};
    end

    // Next-state, output-beat and FIFO-pop logic.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data_d   = data_q;
        keep_d   = keep_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        carry_d  = carry_q;
        rem_d    = rem_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        hdr_rden = '0;
        pld_rden = 1'b0;
        take     = (rem_q > DWS_L) ? DWS_L : rem_q;

        if (slot_free) begin
            valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        valid_d                 = 1'b1;
                        sop_d                   = 1'b1;
                        data_d                  = '0;
                        data_d[HDR_WIDTH-1:0]   = hdr_sel;
                        hdr_rden[pick]          = 1'b1;
                        grant_d                 = pick;
                        rr_ptr_d                = (pick == GW'(NUM_CH-1)) ? '0 : pick + GW'(1);
                        if (sel_has_data) begin
                            data_d[DATA_WIDTH-1:HDR_WIDTH] = tx.pld_rdata_i[DATA_WIDTH-HDR_WIDTH-1:0];
                            carry_d  = tx.pld_rdata_i[DATA_WIDTH-1:DATA_WIDTH-HDR_WIDTH];
                            pld_rden = 1'b1;
                            if (sel_len > HDR_ROOM) begin
                                rem_d   = sel_len - HDR_ROOM;
                                keep_d  = dw_mask(DWS_L);
                                eop_d   = 1'b0;
                                state_d = S_DATA;
                            end else begin
                                rem_d   = '0;
                                keep_d  = dw_mask(sel_len + 11'd4);
                                eop_d   = 1'b1;
                            end
                        end else begin
                            rem_d  = '0;
                            keep_d = dw_mask(11'd4);
                            eop_d  = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (rem_q > 11'd4) begin
                        // More payload owed: a dry payload FIFO yields a bubble.
                        if (!tx.pld_empty_i) begin
                            valid_d  = 1'b1;
                            sop_d    = 1'b0;
                            data_d   = {tx.pld_rdata_i[DATA_WIDTH-HDR_WIDTH-1:0], carry_q};
                            carry_d  = tx.pld_rdata_i[DATA_WIDTH-1:DATA_WIDTH-HDR_WIDTH];
                            pld_rden = 1'b1;
                            keep_d   = dw_mask(take);
                            rem_d    = rem_q - take;
                            eop_d    = (rem_q <= DWS_L);
                            state_d  = (rem_q <= DWS_L) ? S_IDLE : S_DATA;
                        end
                    end else begin
                        // Tail fits entirely in the carried 4 DWs.
                        valid_d               = 1'b1;
                        sop_d                 = 1'b0;
                        data_d                = '0;
                        data_d[HDR_WIDTH-1:0] = carry_q;
                        keep_d                = dw_mask(rem_q);
                        rem_d                 = '0;
                        eop_d                 = 1'b1;
                        state_d               = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            keep_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            carry_q  <= '0;
            rem_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            keep_q   <= keep_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            carry_q  <= carry_d;
            rem_q    <= rem_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // Pops are suppressed while reset is held so nothing is consumed in that cycle.
    assign tx.hdr_rden_o  = hdr_rden & {NUM_CH{rst_n}};
    assign tx.pld_rden_o  = pld_rden & rst_n;
    assign tx.tlp_valid_o = valid_q;
    assign tx.tlp_data_o  = data_q;
    assign tx.tlp_keep_o  = keep_q;
    assign tx.tlp_sop_o   = sop_q;
    assign tx.tlp_eop_o   = eop_q;
    assign grant_o        = grant_q;

endmodule

// File: tb/tb_pcie_tlp_tx_mux.sv
// Bench for pcie_tlp_tx_mux (NUM_CH=2, DATA_WIDTH=256): queue-based FIFO models,
// a DW-stream reference model and a per-cycle output compare.
module tb_pcie_tlp_tx_mux;
    localparam int NUM_CH = 2;
    localparam int DW_W   = 256;
    localparam int HW     = 128;
    localparam int DWS    = DW_W / 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] grant_o;

    pcie_tlp_tx_mux_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW_W), .HDR_WIDTH(HW)) bus ();

    pcie_tlp_tx_mux #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW_W), .HDR_WIDTH(HW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx      (bus),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW_W-1:0] data;
        logic [DWS-1:0]  keep;
        logic            sop;
        logic            eop;
        int              ch;
    } beat_t;

    beat_t           exp_q[$];
    logic [HW-1:0]   hdr_q[NUM_CH][$];
    logic [DW_W-1:0] pld_q[$];
    int              acc_cyc_q[$];
    bit              pld_stall = 1'b0;
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;
    int              acc_cnt = 0;
    int              pld_pops = 0;
    int              hdr_pops[NUM_CH];
    int              gap_cnt = 0;
    bit              in_pkt = 1'b0;

    task automatic check(input string name, input logic [DW_W-1:0] act, input logic [DW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input bit wr, input int len10, input int tag);
        logic [HW-1:0] h;
        h[31:0]   = {1'b0, wr, 12'h000, tag[7:0], len10[9:0]};
        h[63:32]  = {16'hC0DE, tag[15:0]};
        h[95:64]  = {16'h1234, ~tag[15:0]};
        h[127:96] = {16'hDEAD, tag[15:0]};
        return h;
    endfunction

    function automatic logic [DW_W-1:0] mk_pld(input int tag, input int bi);
        logic [DW_W-1:0] p;
        for (int d = 0; d < DWS; d++) begin
            p[d*32 +: 32] = {tag[15:0], bi[7:0], d[7:0]};
        end
        return p;
    endfunction

    // Reference model: flatten header + len payload DWs into one DW stream, then
    // cut it into DWS-wide beats. Queues the FIFO contents it implies as well.
    task automatic add_tlp(input int ch, input bit wr, input int len10, input int tag);
        logic [HW-1:0]   h;
        logic [DW_W-1:0] pb;
        logic [31:0]     dws[$];
        beat_t           b;
        int              len;
        int              npl;
        h   = mk_hdr(wr, len10, tag);
        len = !wr ? 0 : ((len10 == 0) ? 1024 : len10);
        npl = (len + DWS - 1) / DWS;
        for (int i = 0; i < 4; i++) dws.push_back(h[i*32 +: 32]);
        for (int bi = 0; bi < npl; bi++) begin
            pb = mk_pld(tag, bi);
            pld_q.push_back(pb);
            for (int d = 0; d < DWS; d++) begin
                if (bi*DWS + d < len) dws.push_back(pb[d*32 +: 32]);
            end
        end
        for (int i = 0; i < dws.size(); i += DWS) begin
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < DWS; j++) begin
                if (i + j < dws.size()) begin
                    b.data[j*32 +: 32] = dws[i+j];
                    b.keep[j] = 1'b1;
                end
            end
            b.sop = (i == 0);
            b.eop = (i + DWS >= dws.size());
            b.ch  = ch;
            exp_q.push_back(b);
        end
        hdr_q[ch].push_back(h);
    endtask

    task automatic drive_fifos();
        for (int c = 0; c < NUM_CH; c++) begin
            bus.hdr_empty_i[c] = (hdr_q[c].size() == 0);
            bus.hdr_rdata_i[c*HW +: HW] = (hdr_q[c].size() != 0) ? hdr_q[c][0] : '0;
        end
        bus.pld_empty_i = (pld_q.size() == 0) || pld_stall;
        bus.pld_rdata_i = (pld_q.size() != 0) ? pld_q[0] : '0;
    endtask

    // FIFO models: pops sampled mid-cycle, applied at the edge, new data after it.
    initial begin : fifo_drv
        logic [NUM_CH-1:0] hr;
        logic              pr;
        for (int c = 0; c < NUM_CH; c++) hdr_pops[c] = 0;
        drive_fifos();
        forever begin
            @(negedge clk);
            hr = bus.hdr_rden_o;
            pr = bus.pld_rden_o;
            @(posedge clk);
            if (rst_n) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (hr[c] && hdr_q[c].size() != 0) begin
                        void'(hdr_q[c].pop_front());
                        hdr_pops[c]++;
                    end
                end
                if (pr && pld_q.size() != 0) begin
                    void'(pld_q.pop_front());
                    pld_pops++;
                end
            end
            #1;
            drive_fifos();
        end
    end

    // Per-cycle compare against the model, plus hold/legality checks.
    initial begin : compare
        bit              held;
        logic [DW_W-1:0] h_data;
        logic [DWS-1:0]  h_keep;
        logic            h_sop, h_eop;
        beat_t           e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                check("hdr_pop_while_empty", DW_W'(bus.hdr_rden_o & bus.hdr_empty_i), '0);
                check("pld_pop_while_empty", DW_W'(bus.pld_rden_o & bus.pld_empty_i), '0);
                check("hdr_pop_onehot", DW_W'($countones(bus.hdr_rden_o) > 1), '0);
                if (held) begin
                    check("stall_valid", DW_W'(bus.tlp_valid_o), DW_W'(1));
                    check("stall_data", bus.tlp_data_o, h_data);
                    check("stall_keep_sop_eop", DW_W'({bus.tlp_keep_o, bus.tlp_sop_o, bus.tlp_eop_o}),
                          DW_W'({h_keep, h_sop, h_eop}));
                end
                if (in_pkt && !bus.tlp_valid_o) gap_cnt++;
                if (bus.tlp_valid_o && !bus.tlp_ready_i) begin
                    check("stall_no_pop", DW_W'({bus.hdr_rden_o, bus.pld_rden_o}), '0);
                    held   = 1'b1;
                    h_data = bus.tlp_data_o;
                    h_keep = bus.tlp_keep_o;
                    h_sop  = bus.tlp_sop_o;
                    h_eop  = bus.tlp_eop_o;
                end else begin
                    held = 1'b0;
                end
                if (bus.tlp_valid_o && bus.tlp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", DW_W'(1), '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", bus.tlp_data_o, e.data);
                        check("beat_keep", DW_W'(bus.tlp_keep_o), DW_W'(e.keep));
                        check("beat_sop_eop", DW_W'({bus.tlp_sop_o, bus.tlp_eop_o}), DW_W'({e.sop, e.eop}));
                        check("beat_grant", DW_W'(grant_o), DW_W'(e.ch));
                        acc_cnt++;
                        acc_cyc_q.push_back(cyc);
                        in_pkt = !e.eop;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        check(name, DW_W'(exp_q.size()), '0);
        tick(2);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!bus.tlp_valid_o && k < budget) begin
            tick(1);
            k++;
        end
        check(name, DW_W'(bus.tlp_valid_o), DW_W'(1));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p0, h0, h1, base, k;
        bus.tlp_ready_i = 1'b1;
        rst_n = 1'b0;
        tick(3);
        check("reset_valid_sop_eop", DW_W'({bus.tlp_valid_o, bus.tlp_sop_o, bus.tlp_eop_o}), '0);
        check("reset_data", bus.tlp_data_o, '0);
        check("reset_keep_grant", DW_W'({bus.tlp_keep_o, grant_o}), '0);
        check("reset_pops", DW_W'({bus.hdr_rden_o, bus.pld_rden_o}), '0);
        rst_n = 1'b1;
        tick(2);
        check("idle_no_valid", DW_W'(bus.tlp_valid_o), '0);

        // Both channels eligible with len=4 writes: grants 0,1,0,1 back-to-back.
        p0 = pld_pops;
        acc_cyc_q.delete();
        add_tlp(0, 1'b1, 4, 1);
        add_tlp(1, 1'b1, 4, 2);
        add_tlp(0, 1'b1, 4, 3);
        add_tlp(1, 1'b1, 4, 4);
        check("model_rr_beats", DW_W'(exp_q.size()), DW_W'(4));
        check("model_rr_keep", DW_W'({exp_q[0].keep, exp_q[0].sop, exp_q[0].eop}), DW_W'({8'hFF, 2'b11}));
        wait_drain("rr_drain", 40);
        check("rr_back_to_back", DW_W'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[0]), DW_W'(3));
        check("rr_pld_pops", DW_W'(pld_pops - p0), DW_W'(4));

        // Ch1 read header: one beat, header pop only.
        p0 = pld_pops;
        h1 = hdr_pops[1];
        add_tlp(1, 1'b0, 1, 5);
        check("model_rd_keep", DW_W'({exp_q[0].keep, exp_q[0].sop, exp_q[0].eop}), DW_W'({8'h0F, 2'b11}));
        wait_drain("rd_drain", 20);
        check("rd_pld_pops", DW_W'(pld_pops - p0), '0);
        check("rd_hdr_pops", DW_W'(hdr_pops[1] - h1), DW_W'(1));

        // Ch0 write len=4: single full beat.
        p0 = pld_pops;
        add_tlp(0, 1'b1, 4, 6);
        check("model_len4_pld_dw0", DW_W'(exp_q[0].data[159:128]), DW_W'(32'h0006_0000));
        wait_drain("len4_drain", 20);
        check("len4_pld_pops", DW_W'(pld_pops - p0), DW_W'(1));

        // Ch0 write len=8: two beats, tail from carried upper half.
        p0 = pld_pops;
        add_tlp(0, 1'b1, 8, 7);
        check("model_len8_beats", DW_W'(exp_q.size()), DW_W'(2));
        check("model_len8_keeps", DW_W'({exp_q[0].keep, exp_q[1].keep}), DW_W'(16'hFF0F));
        check("model_len8_tail_dw", DW_W'(exp_q[1].data[31:0]), DW_W'(32'h0007_0004));
        check("model_len8_tail_hi", exp_q[1].data[255:128], '0);
        wait_drain("len8_drain", 20);
        check("len8_pld_pops", DW_W'(pld_pops - p0), DW_W'(1));

        // len=0 (1024 DW) with a 3-cycle payload stall mid-packet.
        p0 = pld_pops;
        add_tlp(0, 1'b1, 0, 8);
        check("model_max_beats", DW_W'(exp_q.size()), DW_W'(129));
        check("model_max_last", DW_W'({exp_q[128].keep, exp_q[128].eop}), DW_W'({8'h0F, 1'b1}));
        gap_cnt = 0;
        base = acc_cnt;
        k = 0;
        while (acc_cnt < base + 40 && k < 200) begin
            tick(1);
            k++;
        end
        check("max_progress", DW_W'(acc_cnt >= base + 40), DW_W'(1));
        @(negedge clk);
        pld_stall = 1'b1;
        repeat (3) @(negedge clk);
        pld_stall = 1'b0;
        wait_drain("max_drain", 400);
        check("max_gap", DW_W'(gap_cnt), DW_W'(3));
        check("max_pld_pops", DW_W'(pld_pops - p0), DW_W'(128));

        // Ch0 write blocked on payload, ch1 read goes first.
        @(negedge clk);
        pld_stall = 1'b1;
        add_tlp(1, 1'b0, 1, 9);
        add_tlp(0, 1'b1, 4, 10);
        tick(8);
        check("blocked_write_waits", DW_W'(exp_q.size()), DW_W'(1));
        @(negedge clk);
        pld_stall = 1'b0;
        wait_drain("blocked_drain", 20);

        // Downstream stall for 5 cycles mid-packet.
        add_tlp(0, 1'b1, 16, 11);
        check("model_len16_keeps", DW_W'({exp_q[0].keep, exp_q[1].keep, exp_q[2].keep}), DW_W'(24'hFFFF0F));
        wait_valid("len16_valid", 20);
        bus.tlp_ready_i = 1'b0;
        p0 = pld_pops;
        h0 = hdr_pops[0];
        tick(5);
        check("stall_pld_pops", DW_W'(pld_pops - p0), '0);
        check("stall_hdr_pops", DW_W'(hdr_pops[0] - h0), '0);
        bus.tlp_ready_i = 1'b1;
        wait_drain("len16_drain", 20);

        // Reset mid-packet, then both channels: ch0 must win first.
        add_tlp(0, 1'b1, 16, 12);
        wait_valid("rst_pkt_valid", 20);
        tick(1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid_drop", DW_W'(bus.tlp_valid_o), '0);
        check("rst_no_pops", DW_W'({bus.hdr_rden_o, bus.pld_rden_o}), '0);
        exp_q.delete();
        pld_q.delete();
        for (int c = 0; c < NUM_CH; c++) hdr_q[c].delete();
        in_pkt = 1'b0;
        tick(2);
        check("rst_grant_zero", DW_W'(grant_o), '0);
        rst_n = 1'b1;
        add_tlp(0, 1'b0, 1, 13);
        add_tlp(1, 1'b0, 1, 14);
        wait_drain("post_rst_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pcie_tlp_tx_mux.md
Name: pcie_tlp_tx_mux

Overview:
- Multi-channel TLP transmit assembler. It drains NUM_CH header FIFOs (AW-style write headers, AR-style read headers, ...) and one shared payload FIFO, and emits a framed TLP beat stream (sop/eop/keep) toward the PCIe link layer.
- Arbitrates round-robin across header channels.
- Realigns payload behind the 4DW header across beats, so data DWs are packed contiguously after the header.
- Sits between the header/payload SAL_FIFOs and the link/PIPE TX path.

Parameters:
- NUM_CH, 2, number of header channels (1..8).
- DATA_WIDTH, 256, payload and output beat width in bits; must be a multiple of 128 and at least 256.
- HDR_WIDTH, 128, header width (4DW TLP header); fixed at 128.
- DWS, DATA_WIDTH/32, DWs per beat (derived localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hdr_empty_i  in  NUM_CH  per-channel header FIFO empty.
- hdr_rdata_i  in  NUM_CH*HDR_WIDTH  per-channel show-ahead header data; channel c occupies bits [c*128 +: 128].
- hdr_rden_o  out  NUM_CH  header pop, one-hot, 1-cycle pulse.
- pld_empty_i  in  1  payload FIFO empty.
- pld_rdata_i  in  DATA_WIDTH  show-ahead payload beat; DW0 in bits [31:0].
- pld_rden_o  out  1  payload pop.
- tlp_valid_o  out  1  output beat valid.
- tlp_data_o  out  DATA_WIDTH  output beat.
- tlp_keep_o  out  DWS  per-DW valid mask, contiguous from bit 0.
- tlp_sop_o  out  1  first beat of TLP.
- tlp_eop_o  out  1  last beat of TLP.
- tlp_ready_i  in  1  downstream accept.
- grant_o  out  $clog2(NUM_CH) (minimum 1)  channel of the TLP in flight (debug).

Behaviour:
- Clock and reset: single clk domain; rst_n asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, carry register 0, remaining-DW counter 0. Reset mid-packet abandons the packet; no pops occur in the reset cycle.
- FIFO convention: rdata is valid whenever !empty. Assert rden only when !empty; the entry is consumed at that clock edge.
- Header decode (DW0 = hdr[31:0]):
  - has_data = hdr[30] (Fmt[1]).
  - len = hdr[9:0]; len==0 means 1024 DW.
  - When has_data==0, len is ignored and no payload is consumed.
- Output register: one stage. It may load a new beat only when !tlp_valid_o || tlp_ready_i. While tlp_valid_o && !tlp_ready_i, data, keep, sop and eop hold stable and no FIFO pops occur.
- Eligibility: channel c is eligible when !hdr_empty_i[c] && (!has_data(c) || !pld_empty_i). A read header never waits on payload.
- Arbitration: round-robin. Search starts at (last_grant+1) mod NUM_CH, first eligible channel wins. The pointer updates only when a grant is taken.
- States:
  - IDLE
    - Requires: an eligible channel exists and the output slot is free.
    - Load beat0: data[127:0]=hdr, keep[3:0]=1, sop=1; pop the header.
    - If has_data: data[DATA_WIDTH-1:128]=pld[DATA_WIDTH-129:0], pop payload, carry<=pld[DATA_WIDTH-1:DATA_WIDTH-128], rem<=len-(DWS-4) (signed, floor 0). Beat0 keep = 4+min(len,DWS-4) DW.
    - eop=1 if 4+len <= DWS (or if no data). Next state: IDLE if eop, else DATA.
  - DATA (the beat loads when the output slot is free)
    - If rem > 4 (more payload beats owed): requires !pld_empty_i, otherwise tlp_valid_o drops to 0 (bubble) and the state holds.
      - Beat = {pld low DATA_WIDTH-128 bits, carry}; pop payload; carry<=pld high 128 bits.
      - keep = min(rem,DWS) DW; rem<=rem-min(rem,DWS).
    - If rem <= 4 (tail, carry only): beat = {0, carry}, keep=rem DW, no pop, eop=1, go to IDLE.
    - eop is also asserted whenever rem <= DWS after the beat; go to IDLE if rem would reach 0.
- Timing and throughput:
  - Header pop to output valid: 1 cycle.
  - Back-to-back TLPs without idle cycles: IDLE may grant the next channel in the cycle the eop beat is accepted.
- Payload accounting: payload pops per TLP = ceil(len/DWS). Unused upper DWs of the final payload beat are discarded. The next TLP's payload starts at a fresh FIFO beat.
- Simultaneous events: a hdr_rden_o pulse coincident with a new write into that FIFO is legal. When all channels become eligible in the same cycle, the pointer order decides.

Test Plan (DATA_WIDTH=256, NUM_CH=2):
- Ch1 read header, has_data=0, len=1 -> one beat: sop=eop=1, keep=8'h0F, data[127:0]=hdr; hdr_rden_o=2'b10 for 1 cycle; pld_rden_o never asserted.
- Ch0 write, len=4, payload P0 -> one beat {P0[127:0],hdr}, keep=8'hFF, sop=eop=1; exactly 1 payload pop.
- Ch0 write, len=8, P0 -> beat1 {P0[127:0],hdr} keep FF sop; beat2 {0,P0[255:128]} keep 0F eop; 1 payload pop total.
- len=0 (1024 DW), payload FIFO stalls 3 cycles mid-packet -> 129 beats with a 3-cycle valid gap; 128 payload pops; last beat keep 0F with eop.
- Both channels permanently eligible with len=4 writes -> grant_o sequence 0,1,0,1; TLPs back-to-back with no idle cycle. Ch0 write while payload FIFO empty plus ch1 read -> ch1 is served first.
- tlp_ready_i=0 for 5 cycles mid-packet -> outputs stable, no pops. Then rst_n low mid-packet -> tlp_valid_o=0 immediately; after release, the first grant goes to ch0.
